// File: rtl/hs32_intctl_if.sv
// hs32_intctl_if: peripheral, config and CPU-side signals of the interrupt controller
interface hs32_intctl_if #(
  parameter int IRQ_LINES = 24
);
  logic [IRQ_LINES-1:0] irq_in;
  logic                 nmi_in;
  logic                 cfg_we;
  logic [4:0]           cfg_addr;
  logic [31:0]          cfg_wdata;
  logic [31:0]          cfg_rdata;
  logic [IRQ_LINES-1:0] pending;
  logic                 intrq;
  logic [4:0]           vec;
  logic [31:0]          handler;
  logic                 nmi;
  logic                 iack;
  modport master (
    output irq_in, nmi_in, cfg_we, cfg_addr, cfg_wdata, iack,
    input  cfg_rdata, pending, intrq, vec, handler, nmi
  );
  modport slave (
    input  irq_in, nmi_in, cfg_we, cfg_addr, cfg_wdata, iack,
    output cfg_rdata, pending, intrq, vec, handler, nmi
  );
endinterface

// File: rtl/hs32_intctl.sv
// hs32_intctl: edge-triggered interrupt controller with vector table, NMI and iack handshake
module hs32_intctl #(
  parameter int          IRQ_LINES   = 24,
  parameter logic [31:0] NMI_HANDLER = 32'h0000_0004
) (
  input  logic          i_clk,
  input  logic          reset,
  hs32_intctl_if.slave  bus
);
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [5:0] NL = 6'(IRQ_LINES);
  state_t               state, state_n;
  logic [31:0]          tbl [IRQ_LINES];
  logic [IRQ_LINES-1:0] irq_q, pend, en, serv, clr;
  logic                 nmi_q, nmi_pend, nmi_r, latch, ack;
  logic [4:0]           vec_r, sel;
  logic [31:0]          handler_r;
  logic                 in_rng;
  assign in_rng = {1'b0, bus.cfg_addr} < NL;
  always_comb begin
    en = '0;
    sel = '0;
    for (int i = 0; i < IRQ_LINES; i++) en[i] = tbl[i][0];
    serv = pend & en;
    for (int i = IRQ_LINES - 1; i >= 0; i--) sel = serv[i] ? 5'(i) : sel;
  end
  always_comb begin
    latch = state == IDLE && (nmi_pend || |serv);
    ack = state == REQ && bus.iack;
    state_n = latch ? REQ : ack ? IDLE : state;
    clr = (ack && !nmi_r) ? {{(IRQ_LINES-1){1'b0}}, 1'b1} << vec_r : '0;
  end
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state <= IDLE;
      irq_q <= '0;
      nmi_q <= 1'b0;
      pend <= '0;
      nmi_pend <= 1'b0;
      nmi_r <= 1'b0;
      vec_r <= '0;
      handler_r <= '0;
      for (int i = 0; i < IRQ_LINES; i++) tbl[i] <= '0;
    end else begin
      state <= state_n;
      irq_q <= bus.irq_in;
      nmi_q <= bus.nmi_in;
      // a fresh edge on the acknowledged line re-arms it
      pend <= (pend & ~clr) | (bus.irq_in & ~irq_q);
      nmi_pend <= (nmi_pend & ~(ack & nmi_r)) | (bus.nmi_in & ~nmi_q);
      if (latch) begin
        nmi_r <= nmi_pend;
        vec_r <= nmi_pend ? 5'd31 : sel;
        handler_r <= nmi_pend ? NMI_HANDLER : {tbl[sel][31:2], 2'b00};
      end
      if (bus.cfg_we && in_rng) tbl[bus.cfg_addr] <= bus.cfg_wdata & 32'hFFFF_FFFD;
    end
  end
  assign bus.cfg_rdata = in_rng ? tbl[bus.cfg_addr] : '0;
  assign bus.pending = pend;
  assign bus.intrq = state == REQ;
  assign bus.vec = vec_r;
  assign bus.handler = handler_r;
  assign bus.nmi = nmi_r;
endmodule
